// File: rtl/trng_word_packer.sv
// Packs debiased TRNG bits LSB-first into WORD_W-bit words and queues them in a small FIFO.
// Optional repetition-count health test is compiled in when TRNG_HEALTH_EN is defined.
module trng_word_packer #(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RCT_LIMIT  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic [WORD_W-1:0]             word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          health_fail
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  // Refuse to elaborate with parameters the datapath cannot support.
  if (WORD_W < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RCT_LIMIT < 2)
  begin : g_bad_cfg
    $error("trng_word_packer: unsupported parameter set");
  end

  // Partial word: bits 0..WORD_W-2 collected so far, shifted in from the top.
  logic [WORD_W-2:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_shift;

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;

  logic accept;
  logic trip;
  logic push_req;
  logic push;
  logic pop;
  logic full;

`ifdef TRNG_HEALTH_EN
  localparam int unsigned RUN_W = $clog2(RCT_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RCT_LIMIT);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             hf_q, hf_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    hf_d   = hf_q;
    trip   = 1'b0;
    if (bit_valid && !hf_q) begin
      last_d = bit_in;
      if (run_q == '0 || bit_in != last_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end
      if (run_d == RUN_MAX) begin
        trip = 1'b1;
        hf_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      last_q <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
      hf_q   <= hf_d;
    end
  end

  // Once the alarm is raised the source is untrusted: no further bits are packed.
  assign accept      = bit_valid && !hf_q && !trip;
  assign health_fail = hf_q;
`else
  assign trip        = 1'b0;
  assign accept      = bit_valid;
  assign health_fail = 1'b0;
`endif

  assign sr_shift = {bit_in, sr_q} >> 1;

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    if (trip) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == LAST_IDX) begin
        push_req = 1'b1;
        sr_d     = '0;
        cnt_d    = '0;
      end else begin
        sr_d  = sr_shift[WORD_W-2:0];
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign word_valid = (count_q != '0);
  assign word_out   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  assign pop  = word_valid && word_ready;
  assign full = (count_q == FULL_CNT);
  // A pop on the same edge frees the slot, so a full FIFO can still take the word.
  assign push = push_req && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_req && full && !pop);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is cleared on reset so word_out reads 0 afterwards; this keeps the
  // array in flops rather than RAM, which is fine at this depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {bit_in, sr_q};
    end
  end

endmodule

// File: tb/tb_trng_word_packer.sv
// Scoreboard bench for trng_word_packer: a behavioural packer/queue model predicts every output
// each cycle; expected words are queued on completion and compared when the DUT pops them.
module tb_trng_word_packer;

  localparam int WORD_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int RCT_LIMIT  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       health_fail;

  trng_word_packer #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RCT_LIMIT  (RCT_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] exp_q [$];
  logic [7:0] m_word;
  int         m_cnt;
  bit         m_ovf;
  bit         m_hf;
  int         m_run;
  bit         m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("word_valid", word_valid, exp_q.size() != 0);
    check("fifo_count", fifo_count, exp_q.size());
    check("overflow", overflow, m_ovf);
    check("health_fail", health_fail, m_hf);
    if (exp_q.size() != 0) check("word_out", word_out, exp_q[0]);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_word = '0;
    m_cnt  = 0;
    m_ovf  = 0;
    m_hf   = 0;
    m_run  = 0;
    m_last = 0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check("rst_word_out", word_out, 0);
    check_outputs();
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic b, input logic v, input logic rdy);
    bit         pop;
    bit         push_req;
    logic [7:0] done_word;
    bit_in     = b;
    bit_valid  = v;
    word_ready = rdy;
    pop       = rdy && (exp_q.size() != 0);
    push_req  = 0;
    done_word = '0;
    if (pop) check("pop_word", word_out, exp_q[0]);
    if (v && !m_hf) begin
`ifdef TRNG_HEALTH_EN
      if (m_run == 0 || b != m_last) m_run = 1;
      else if (m_run < RCT_LIMIT) m_run++;
      m_last = b;
      if (m_run == RCT_LIMIT) begin
        m_hf  = 1;
        m_cnt = 0;
      end
`endif
      if (!m_hf) begin
        m_word[m_cnt] = b;
        if (m_cnt == WORD_W - 1) begin
          push_req  = 1;
          done_word = m_word;
          m_cnt     = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (push_req) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(done_word);
      else m_ovf = 1;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_last);
    for (int i = 0; i < WORD_W; i++) step(w[i], 1'b1, (i == WORD_W - 1) ? rdy_last : 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w1;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
    model_clear();

    // 1: basic word 8'h8D, then one pop
    do_reset();
    w1 = 8'h8D;
    send_word(w1, 1'b0);
    check("t1_word", word_out, 8'h8D);
    check("t1_count", fifo_count, 1);
    step(1'b0, 1'b0, 1'b1);
    check("t1_empty", word_valid, 0);

    // 2: bit_valid toggling, all ones -> one 8'hFF
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2) == 0, 1'b0);
    check("t2_count", fifo_count, 1);
    check("t2_word", word_out, 8'hFF);
    drain(1);

    // 3: overflow with consumer stalled
    do_reset();
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b0);
    send_word(8'h81, 1'b0);
    check("t3_count", fifo_count, 4);
    check("t3_ovf", overflow, 1);
    check("t3_head", word_out, 8'hA5);
    drain(5);
    check("t3_ovf_sticky", overflow, 1);

    // 4: pop on the edge the 5th word completes
    do_reset();
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b0);
    send_word(8'h81, 1'b1);
    check("t4_ovf", overflow, 0);
    check("t4_count", fifo_count, 4);
    check("t4_head", word_out, 8'h3C);
    drain(4);

    // 5: reset mid-word discards partial bits
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    do_reset();
    send_word(8'h5A, 1'b0);
    check("t5_word", word_out, 8'h5A);
    check("t5_count", fifo_count, 1);
    drain(1);

    // 6: long run of ones
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0);
`ifdef TRNG_HEALTH_EN
    check("t6_hf", health_fail, 1);
    check("t6_count", fifo_count, 3);
`else
    check("t6_hf", health_fail, 0);
    check("t6_count", fifo_count, 4);
`endif
    for (int i = 0; i < 8; i++) step(i[0], 1'b1, 1'b0);
    drain(5);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
